calc1_port_arbiter: RTL and testbench
=====================================

Name: calc1_port_arbiter

Overview:
- Front-end scheduler for the CALC1 four-port calculator. It captures two-cycle requests (command + operand1, then operand2) on ports a–d and holds one outstanding request per port.
- It grants a single shared ALU back-end in round-robin order using a valid/ready issue handshake and a tagged result return.
- It routes each result back to the originating port's response/data outputs. It sits between the port interface and the arithmetic units.

Parameters:
- DATA_W, 32, operand/result width
- RR_EN, 1, 1 = round-robin grant; 0 = fixed priority (a > b > c > d)

Ports:
- c_clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- reqcmd_a/b/c/d  in  4 each  request command per port (0 = no-op)
- reqa/b/c/d_data_in  in  DATA_W each  operand1 in command cycle, operand2 in the next cycle
- out_resp_a/b/c/d  out  2 each  00 none, 01 success, 10 overflow/underflow/invalid, 11 unused
- out_data_a/b/c/d  out  DATA_W each  result, valid only when out_resp = 01
- alu_vld  out  1  issue valid
- alu_rdy  in  1  ALU accepts issue
- alu_cmd  out  4  issued command
- alu_op1, alu_op2  out  DATA_W  issued operands
- alu_tag  out  2  issuing port (0 = a … 3 = d)
- alu_rsp_vld  in  1  result valid, one per cycle max
- alu_rsp_tag  in  2  port of the result
- alu_rsp  in  2  ALU response code
- alu_rsp_data  in  DATA_W  ALU result
- err_unexp  out  1  sticky: a result arrived for a port not in BUSY

Behaviour:
- Reset (reset = 0, async):
  - All ports go to IDLE; round-robin pointer = d, so a has first priority.
  - alu_vld = 0 and alu_cmd/op1/op2/tag = 0.
  - All out_resp = 00, all out_data = 0, err_unexp = 0.
  - Any in-flight results are discarded.
- Per-port FSM:
  - IDLE: reqcmd ≠ 0 at cycle t → latch cmd and op1, go to OP2.
  - OP2: at t+1, latch op2. If cmd ∉ {1, 2, 5, 6}, go to RESP with code 10. Otherwise go to PEND.
  - PEND: wait for grant.
  - BUSY: issued; wait for alu_rsp_vld with matching tag.
  - RESP: drive out_resp/out_data for exactly 1 cycle, then go to IDLE.
- Commands are sampled only in IDLE. A nonzero reqcmd in OP2/PEND/BUSY/RESP is ignored, with no response.
- Grant:
  - When alu_vld = 0 or the issue is accepted, select the next PEND port after the pointer (or the lowest index if RR_EN = 0).
  - Register it onto alu_*: alu_vld rises the cycle after the port enters PEND, i.e. earliest at t+3.
  - Payload stays stable while alu_vld = 1 and alu_rdy = 0.
  - On alu_vld && alu_rdy: that port goes PEND → BUSY and the pointer moves to it. The next PEND port may be presented the following cycle (throughput 1 issue/cycle).
- Return:
  - alu_rsp_vld at cycle u with tag k and port k BUSY → port k enters RESP.
  - out_resp_k = alu_rsp and out_data_k = alu_rsp_data at u+1.
  - out_data is forced to 0 unless the code is 01.
- Invalid-command response: out_resp = 10 appears at t+2.
- Simultaneous events:
  - An invalid-command response on one port and an ALU return on another in the same cycle are both delivered.
  - The issue and return of the same port in one cycle cannot occur (BUSY precedes return).
- Unexpected tag (port not BUSY): result dropped, err_unexp set and held until reset.
- Every port returns to IDLE after RESP. The same port may present a new command in the RESP cycle's following cycle at the earliest.

Decomposition:
- Package calc1_pkg:
  - command constants CMD_NOP = 0, CMD_ADD = 1, CMD_SUB = 2, CMD_SHL = 5, CMD_SHR = 6
  - response constants RSP_NONE, RSP_OK, RSP_ERR
  - port-state enum typedef {IDLE, OP2, PEND, BUSY, RESP}
  - port_req_t struct {cmd, op1, op2}
- Sub-module calc1_port_slot: one per port, 4 instances. Holds the FSM, operand registers and response register.
- Top level: round-robin grant, issue register and return demux.

Test Plan:
- Single request: port a, cmd 1, op1 = 5, op2 = 7, alu_rdy = 1 → alu_vld at t+3 with tag 0, op1 = 5, op2 = 7. Return rsp 01 / data 12 → out_resp_a = 01, out_data_a = 12 one cycle later.
- Round-robin fairness: a–d all issue cmd 1 in the same cycle → issue tags 0, 1, 2, 3 on consecutive cycles. Repeat the burst with the pointer at b → order 2, 3, 0, 1.
- Back-pressure: alu_rdy = 0 for 5 cycles with port c pending → alu_vld held with payload stable. No state change until alu_rdy = 1, then BUSY.
- Invalid command: port b cmd 3 → out_resp_b = 10 at t+2, out_data_b = 0, no alu_vld.
- Ignored command: port d BUSY, reqcmd_d = 2 → ignored. Only the original result returns and port d goes to IDLE.
- Unexpected tag and reset mid-operation:
  - alu_rsp_vld with tag 1 while b is IDLE → err_unexp = 1 and sticky, no out_resp_b.
  - Assert reset with two ports BUSY → all outputs 0 immediately. A later return with tag 0 sets err_unexp again.

Source files
------------

// File: rtl/calc1_pkg.sv
// rtl/calc1_pkg.sv - shared commands, response codes and types for the CALC1 port arbiter
package calc1_pkg;

  localparam int CALC1_DATA_W = 32;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RSP_NONE = 2'b00;
  localparam logic [1:0] RSP_OK   = 2'b01;
  localparam logic [1:0] RSP_ERR  = 2'b10;

  typedef enum logic [2:0] {IDLE, OP2, PEND, BUSY, RESP} port_state_t;

  typedef struct packed {
    logic [3:0]              cmd;
    logic [CALC1_DATA_W-1:0] op1;
    logic [CALC1_DATA_W-1:0] op2;
  } port_req_t;

  function automatic logic cmd_supported(input logic [3:0] cmd);
    return cmd inside {CMD_ADD, CMD_SUB, CMD_SHL, CMD_SHR};
  endfunction

endpackage

// File: rtl/calc1_port_arbiter_if.sv
// rtl/calc1_port_arbiter_if.sv - port-side and ALU-side signals of the CALC1 port arbiter
interface calc1_port_arbiter_if #(parameter int DATA_W = 32);

  logic [3:0]        reqcmd_a, reqcmd_b, reqcmd_c, reqcmd_d;
  logic [DATA_W-1:0] reqa_data_in, reqb_data_in, reqc_data_in, reqd_data_in;
  logic [1:0]        out_resp_a, out_resp_b, out_resp_c, out_resp_d;
  logic [DATA_W-1:0] out_data_a, out_data_b, out_data_c, out_data_d;

  logic              alu_vld;
  logic              alu_rdy;
  logic [3:0]        alu_cmd;
  logic [DATA_W-1:0] alu_op1, alu_op2;
  logic [1:0]        alu_tag;
  logic              alu_rsp_vld;
  logic [1:0]        alu_rsp_tag;
  logic [1:0]        alu_rsp;
  logic [DATA_W-1:0] alu_rsp_data;
  logic              err_unexp;

  modport slave (
    input  reqcmd_a, reqcmd_b, reqcmd_c, reqcmd_d,
    input  reqa_data_in, reqb_data_in, reqc_data_in, reqd_data_in,
    output out_resp_a, out_resp_b, out_resp_c, out_resp_d,
    output out_data_a, out_data_b, out_data_c, out_data_d,
    output alu_vld, alu_cmd, alu_op1, alu_op2, alu_tag,
    input  alu_rdy, alu_rsp_vld, alu_rsp_tag, alu_rsp, alu_rsp_data,
    output err_unexp
  );

  modport master (
    output reqcmd_a, reqcmd_b, reqcmd_c, reqcmd_d,
    output reqa_data_in, reqb_data_in, reqc_data_in, reqd_data_in,
    input  out_resp_a, out_resp_b, out_resp_c, out_resp_d,
    input  out_data_a, out_data_b, out_data_c, out_data_d,
    input  alu_vld, alu_cmd, alu_op1, alu_op2, alu_tag,
    output alu_rdy, alu_rsp_vld, alu_rsp_tag, alu_rsp, alu_rsp_data,
    input  err_unexp
  );

endinterface

// File: rtl/calc1_port_arbiter_slot.sv
// rtl/calc1_port_arbiter_slot.sv - per-port request FSM holding one outstanding CALC1 request
module calc1_port_slot
  import calc1_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              reqcmd,
  input  logic [CALC1_DATA_W-1:0] data_in,
  input  logic                    grant,
  input  logic                    rsp_hit,
  input  logic [1:0]              rsp,
  input  logic [CALC1_DATA_W-1:0] rsp_data,
  output logic                    pend,
  output logic                    busy,
  output port_req_t               req,
  output logic [1:0]              out_resp,
  output logic [CALC1_DATA_W-1:0] out_data
);

  port_state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req      <= '0;
      out_resp <= RSP_NONE;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (reqcmd != CMD_NOP) begin
            req.cmd <= reqcmd;
            req.op1 <= data_in;
            state   <= OP2;
          end
        end
        OP2: begin
          req.op2 <= data_in;
          if (cmd_supported(req.cmd)) begin
            state <= PEND;
          end else begin
            state    <= RESP;
            out_resp <= RSP_ERR;
            out_data <= '0;
          end
        end
        PEND: begin
          if (grant) state <= BUSY;
        end
        BUSY: begin
          if (rsp_hit) begin
            state    <= RESP;
            out_resp <= rsp;
            // Only a successful result carries data back to the port.
            out_data <= (rsp == RSP_OK) ? rsp_data : '0;
          end
        end
        RESP: begin
          state    <= IDLE;
          out_resp <= RSP_NONE;
          out_data <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pend = (state == PEND);
  assign busy = (state == BUSY);

endmodule

// File: rtl/calc1_port_arbiter.sv
// rtl/calc1_port_arbiter.sv - four-port CALC1 front end: request slots, ALU issue arbiter, result demux
module calc1_port_arbiter
  import calc1_pkg::*;
#(
  parameter int DATA_W = CALC1_DATA_W,
  parameter bit RR_EN  = 1'b1
)
(
  input logic                  c_clk,
  input logic                  reset,
  calc1_port_arbiter_if.slave  bus
);

  logic [3:0]        reqcmd   [4];
  logic [DATA_W-1:0] data_in  [4];
  logic [1:0]        out_resp [4];
  logic [DATA_W-1:0] out_data [4];
  port_req_t         req      [4];
  logic [3:0]        pend, busy, grant, rsp_hit;

  logic              vld_q;
  logic [1:0]        tag_q;
  logic [3:0]        cmd_q;
  logic [DATA_W-1:0] op1_q, op2_q;
  logic [1:0]        ptr;
  logic              err_q;
  logic              fire;

  logic [3:0]        cand;
  logic [1:0]        base;
  logic              sel_vld;
  logic [1:0]        sel;

  assign reqcmd[0]  = bus.reqcmd_a;
  assign reqcmd[1]  = bus.reqcmd_b;
  assign reqcmd[2]  = bus.reqcmd_c;
  assign reqcmd[3]  = bus.reqcmd_d;
  assign data_in[0] = bus.reqa_data_in;
  assign data_in[1] = bus.reqb_data_in;
  assign data_in[2] = bus.reqc_data_in;
  assign data_in[3] = bus.reqd_data_in;

  assign fire = vld_q && bus.alu_rdy;

  for (genvar k = 0; k < 4; k++) begin : g_slot
    calc1_port_slot u_slot (
      .clk      (c_clk),
      .rst_n    (reset),
      .reqcmd   (reqcmd[k]),
      .data_in  (data_in[k]),
      .grant    (grant[k]),
      .rsp_hit  (rsp_hit[k]),
      .rsp      (bus.alu_rsp),
      .rsp_data (bus.alu_rsp_data),
      .pend     (pend[k]),
      .busy     (busy[k]),
      .req      (req[k]),
      .out_resp (out_resp[k]),
      .out_data (out_data[k])
    );
    assign grant[k]   = fire && (tag_q == 2'(k));
    assign rsp_hit[k] = bus.alu_rsp_vld && (bus.alu_rsp_tag == 2'(k)) && busy[k];
  end

  // The port being accepted this cycle is still PEND, so drop it from the
  // candidates and search from it as if the pointer had already moved there.
  always_comb begin
    cand = pend;
    if (fire) cand[tag_q] = 1'b0;
    base    = fire ? tag_q : ptr;
    sel_vld = 1'b0;
    sel     = 2'd0;
    if (RR_EN) begin
      for (int i = 4; i >= 1; i--) begin
        if (cand[base + 2'(i)]) begin
          sel_vld = 1'b1;
          sel     = base + 2'(i);
        end
      end
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (cand[i]) begin
          sel_vld = 1'b1;
          sel     = 2'(i);
        end
      end
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      vld_q <= 1'b0;
      tag_q <= 2'd0;
      cmd_q <= CMD_NOP;
      op1_q <= '0;
      op2_q <= '0;
      ptr   <= 2'd3;
      err_q <= 1'b0;
    end else begin
      if (!vld_q || bus.alu_rdy) begin
        vld_q <= sel_vld;
        tag_q <= sel;
        cmd_q <= sel_vld ? req[sel].cmd : CMD_NOP;
        op1_q <= sel_vld ? req[sel].op1 : '0;
        op2_q <= sel_vld ? req[sel].op2 : '0;
      end
      if (fire) ptr <= tag_q;
      if (bus.alu_rsp_vld && !busy[bus.alu_rsp_tag]) err_q <= 1'b1;
    end
  end

  assign bus.alu_vld    = vld_q;
  assign bus.alu_tag    = tag_q;
  assign bus.alu_cmd    = cmd_q;
  assign bus.alu_op1    = op1_q;
  assign bus.alu_op2    = op2_q;
  assign bus.err_unexp  = err_q;

  assign bus.out_resp_a = out_resp[0];
  assign bus.out_resp_b = out_resp[1];
  assign bus.out_resp_c = out_resp[2];
  assign bus.out_resp_d = out_resp[3];
  assign bus.out_data_a = out_data[0];
  assign bus.out_data_b = out_data[1];
  assign bus.out_data_c = out_data[2];
  assign bus.out_data_d = out_data[3];

endmodule

// File: tb/tb_calc1_port_arbiter.sv
// tb/tb_calc1_port_arbiter.sv - directed and randomized self-checking bench for calc1_port_arbiter
module tb_calc1_port_arbiter;
  import calc1_pkg::*;

  localparam int DW        = 32;
  localparam int RND_CYC   = 3000;
  localparam int DRAIN_CYC = 300;
  localparam int P_FREE = 0, P_OP2 = 1, P_WAIT = 2, P_ALU = 3, P_RSP = 4;

  logic c_clk = 1'b0;
  logic reset;
  always #5 c_clk = ~c_clk;

  calc1_port_arbiter_if #(.DATA_W(DW)) bus ();

  calc1_port_arbiter #(.DATA_W(DW), .RR_EN(1'b1)) dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge c_clk);
    #1;
  endtask

  task automatic drive_req(input int p, input logic [3:0] cmd, input logic [31:0] d);
    case (p)
      0: begin bus.reqcmd_a = cmd; bus.reqa_data_in = d; end
      1: begin bus.reqcmd_b = cmd; bus.reqb_data_in = d; end
      2: begin bus.reqcmd_c = cmd; bus.reqc_data_in = d; end
      default: begin bus.reqcmd_d = cmd; bus.reqd_data_in = d; end
    endcase
  endtask

  function automatic logic [1:0] resp_of(input int p);
    case (p)
      0: return bus.out_resp_a;
      1: return bus.out_resp_b;
      2: return bus.out_resp_c;
      default: return bus.out_resp_d;
    endcase
  endfunction

  function automatic logic [31:0] data_of(input int p);
    case (p)
      0: return bus.out_data_a;
      1: return bus.out_data_b;
      2: return bus.out_data_c;
      default: return bus.out_data_d;
    endcase
  endfunction

  task automatic clear_inputs;
    for (int p = 0; p < 4; p++) drive_req(p, 4'd0, 32'd0);
    bus.alu_rdy      = 1'b0;
    bus.alu_rsp_vld  = 1'b0;
    bus.alu_rsp_tag  = 2'd0;
    bus.alu_rsp      = 2'd0;
    bus.alu_rsp_data = 32'd0;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    clear_inputs();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_vld"}, bus.alu_vld, 0);
    check({nm, "_tag"}, bus.alu_tag, 0);
    check({nm, "_cmd"}, bus.alu_cmd, 0);
    check({nm, "_op1"}, bus.alu_op1, 0);
    check({nm, "_op2"}, bus.alu_op2, 0);
    check({nm, "_err"}, bus.err_unexp, 0);
    for (int p = 0; p < 4; p++) begin
      check({nm, "_resp"}, resp_of(p), RSP_NONE);
      check({nm, "_data"}, data_of(p), 0);
    end
  endtask

  task automatic alu_return(input int p, input logic [1:0] rsp, input logic [31:0] d);
    bus.alu_rsp_vld  = 1'b1;
    bus.alu_rsp_tag  = 2'(p);
    bus.alu_rsp      = rsp;
    bus.alu_rsp_data = d;
    tick();
    bus.alu_rsp_vld  = 1'b0;
  endtask

  task automatic single(input int p, input logic [3:0] cmd, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] r);
    drive_req(p, cmd, a);
    bus.alu_rdy = 1'b1;
    tick();
    drive_req(p, 4'd0, b);
    check("single_t1_vld", bus.alu_vld, 0);
    tick();
    drive_req(p, 4'd0, 32'd0);
    check("single_t2_vld", bus.alu_vld, 0);
    tick();
    check("single_t3_vld", bus.alu_vld, 1);
    check("single_tag", bus.alu_tag, p);
    check("single_cmd", bus.alu_cmd, cmd);
    check("single_op1", bus.alu_op1, a);
    check("single_op2", bus.alu_op2, b);
    tick();
    check("single_t4_vld", bus.alu_vld, 0);
    alu_return(p, RSP_OK, r);
    check("single_resp", resp_of(p), RSP_OK);
    check("single_data", data_of(p), r);
    tick();
    check("single_resp_clear", resp_of(p), RSP_NONE);
  endtask

  task automatic burst(input int start);
    for (int p = 0; p < 4; p++) drive_req(p, CMD_ADD, 32'(p * 10 + 1));
    tick();
    for (int p = 0; p < 4; p++) drive_req(p, 4'd0, 32'(p));
    tick();
    for (int p = 0; p < 4; p++) drive_req(p, 4'd0, 32'd0);
    bus.alu_rdy = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("rr_vld", bus.alu_vld, 1);
      check("rr_tag", bus.alu_tag, (start + i) % 4);
      check("rr_op1", bus.alu_op1, ((start + i) % 4) * 10 + 1);
      check("rr_op2", bus.alu_op2, (start + i) % 4);
      tick();
    end
    check("rr_done_vld", bus.alu_vld, 0);
    for (int i = 0; i < 4; i++) begin
      alu_return(i, RSP_OK, 32'(100 + i));
      check("rr_resp", resp_of(i), RSP_OK);
      check("rr_data", data_of(i), 100 + i);
    end
    tick();
  endtask

  // Randomized reference model state, tracked per port as a transaction phase.
  int          ph[4], free_at[4], req_cyc[4], ret_at[4], due[4];
  logic [3:0]  m_cmd[4];
  logic [31:0] m_op1[4], m_op2[4], m_raw[4];
  logic [1:0]  m_rsp[4];
  logic        stalled;
  logic [1:0]  stall_tag;
  int          issued, completed, k, s, q, pending;
  bit          sent, hit;
  logic [3:0]  cmd_pick;
  logic [3:0]  vcmd[4] = '{4'd1, 4'd2, 4'd5, 4'd6};
  logic [3:0]  icmd[5] = '{4'd3, 4'd4, 4'd7, 4'd9, 4'd15};

  function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd1: return a + b;
      4'd2: return a - b;
      4'd5: return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    do_reset();
    check_all_zero("reset");

    burst(0);
    single(0, CMD_ADD, 32'd5, 32'd7, 32'd12);
    single(1, CMD_SUB, 32'd9, 32'd4, 32'd5);
    burst(2);

    // Back-pressure on port c.
    drive_req(2, CMD_SUB, 32'd50);
    bus.alu_rdy = 1'b0;
    tick();
    drive_req(2, 4'd0, 32'd8);
    tick();
    drive_req(2, 4'd0, 32'd0);
    tick();
    for (int i = 0; i < 6; i++) begin
      check("bp_vld", bus.alu_vld, 1);
      check("bp_tag", bus.alu_tag, 2);
      check("bp_cmd", bus.alu_cmd, CMD_SUB);
      check("bp_op1", bus.alu_op1, 50);
      check("bp_op2", bus.alu_op2, 8);
      bus.alu_rdy = (i == 5);
      tick();
    end
    check("bp_release_vld", bus.alu_vld, 0);
    alu_return(2, RSP_OK, 32'd42);
    check("bp_resp", resp_of(2), RSP_OK);
    check("bp_data", data_of(2), 42);
    check("bp_err", bus.err_unexp, 0);
    tick();

    // Invalid command on port b.
    drive_req(1, 4'd3, 32'd11);
    tick();
    drive_req(1, 4'd0, 32'd22);
    check("inv_t1_resp", resp_of(1), RSP_NONE);
    tick();
    drive_req(1, 4'd0, 32'd0);
    check("inv_resp", resp_of(1), RSP_ERR);
    check("inv_data", data_of(1), 0);
    check("inv_vld", bus.alu_vld, 0);
    tick();
    check("inv_resp_clear", resp_of(1), RSP_NONE);
    check("inv_vld2", bus.alu_vld, 0);

    // Command on port d while BUSY is ignored.
    drive_req(3, CMD_SHL, 32'd3);
    bus.alu_rdy = 1'b1;
    tick();
    drive_req(3, 4'd0, 32'd4);
    tick();
    drive_req(3, 4'd0, 32'd0);
    tick();
    check("ign_issue_tag", bus.alu_tag, 3);
    tick();
    drive_req(3, CMD_SUB, 32'd99);
    for (int i = 0; i < 4; i++) begin
      check("ign_vld", bus.alu_vld, 0);
      check("ign_resp", resp_of(3), RSP_NONE);
      tick();
    end
    drive_req(3, 4'd0, 32'd0);
    alu_return(3, RSP_OK, 32'd48);
    check("ign_ret_resp", resp_of(3), RSP_OK);
    check("ign_ret_data", data_of(3), 48);
    check("ign_err", bus.err_unexp, 0);
    tick();
    check("ign_resp_clear", resp_of(3), RSP_NONE);
    check("ign_vld_after", bus.alu_vld, 0);

    // Unexpected tag while port b is IDLE.
    alu_return(1, RSP_OK, 32'd77);
    check("unexp_err", bus.err_unexp, 1);
    check("unexp_resp_b", resp_of(1), RSP_NONE);
    tick();
    tick();
    check("unexp_sticky", bus.err_unexp, 1);

    // Asynchronous reset with ports a and c BUSY.
    drive_req(0, CMD_ADD, 32'd1);
    drive_req(2, CMD_ADD, 32'd2);
    bus.alu_rdy = 1'b1;
    tick();
    drive_req(0, 4'd0, 32'd3);
    drive_req(2, 4'd0, 32'd4);
    tick();
    drive_req(0, 4'd0, 32'd0);
    drive_req(2, 4'd0, 32'd0);
    tick();
    check("rst_issue_a", bus.alu_tag, 0);
    tick();
    check("rst_issue_c", bus.alu_tag, 2);
    tick();
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    reset = 1'b1;
    alu_return(0, RSP_OK, 32'd4);
    check("post_rst_err", bus.err_unexp, 1);
    check("post_rst_resp_a", resp_of(0), RSP_NONE);

    // Randomized traffic against the transaction-level model.
    do_reset();
    for (int p = 0; p < 4; p++) begin
      ph[p] = P_FREE;
      free_at[p] = 0;
    end
    stalled = 1'b0;
    stall_tag = 2'd0;
    issued = 0;
    completed = 0;
    for (int c = 0; c < RND_CYC + DRAIN_CYC; c++) begin
      for (int p = 0; p < 4; p++) begin
        hit = (ph[p] == P_RSP) && (due[p] == c);
        check("rnd_resp", resp_of(p), hit ? m_rsp[p] : RSP_NONE);
        check("rnd_data", data_of(p), (hit && m_rsp[p] == RSP_OK) ? m_raw[p] : 32'd0);
        if (hit) begin
          ph[p] = P_FREE;
          free_at[p] = c + 1;
          completed++;
        end
      end
      check("rnd_err", bus.err_unexp, 0);

      bus.alu_rdy = ($urandom_range(0, 3) != 0);
      if (stalled) check("rnd_hold_vld", bus.alu_vld, 1);
      if (bus.alu_vld) begin
        k = int'(bus.alu_tag);
        if (stalled) check("rnd_hold_tag", bus.alu_tag, stall_tag);
        check("rnd_issue_pending", ph[k] == P_WAIT, 1);
        check("rnd_issue_cmd", bus.alu_cmd, m_cmd[k]);
        check("rnd_issue_op1", bus.alu_op1, m_op1[k]);
        check("rnd_issue_op2", bus.alu_op2, m_op2[k]);
        check("rnd_issue_latency", c >= req_cyc[k] + 3, 1);
        if (bus.alu_rdy) begin
          ph[k] = P_ALU;
          ret_at[k] = c + $urandom_range(1, 6);
          m_raw[k] = alu_model(m_cmd[k], m_op1[k], m_op2[k]);
          case ($urandom_range(0, 9))
            0: m_rsp[k] = RSP_ERR;
            1: m_rsp[k] = 2'b11;
            default: m_rsp[k] = RSP_OK;
          endcase
          stalled = 1'b0;
          issued++;
        end else begin
          stalled = 1'b1;
          stall_tag = bus.alu_tag;
        end
      end else begin
        stalled = 1'b0;
      end

      bus.alu_rsp_vld = 1'b0;
      sent = 1'b0;
      s = $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) begin
        q = (s + i) % 4;
        if (!sent && ph[q] == P_ALU && ret_at[q] <= c) begin
          bus.alu_rsp_vld  = 1'b1;
          bus.alu_rsp_tag  = 2'(q);
          bus.alu_rsp      = m_rsp[q];
          bus.alu_rsp_data = m_raw[q];
          ph[q] = P_RSP;
          due[q] = c + 1;
          sent = 1'b1;
        end
      end

      for (int p = 0; p < 4; p++) begin
        if (ph[p] == P_OP2) begin
          drive_req(p, 4'($urandom_range(0, 15)), m_op2[p]);
          if (m_cmd[p] inside {4'd1, 4'd2, 4'd5, 4'd6}) begin
            ph[p] = P_WAIT;
          end else begin
            ph[p] = P_RSP;
            due[p] = c + 1;
            m_rsp[p] = RSP_ERR;
            m_raw[p] = 32'd0;
          end
        end else if (ph[p] == P_FREE && free_at[p] <= c) begin
          if (c < RND_CYC && $urandom_range(0, 2) == 0) begin
            cmd_pick = ($urandom_range(0, 4) == 0) ? icmd[$urandom_range(0, 4)] : vcmd[$urandom_range(0, 3)];
            m_cmd[p] = cmd_pick;
            m_op1[p] = $urandom;
            m_op2[p] = $urandom;
            req_cyc[p] = c;
            drive_req(p, cmd_pick, m_op1[p]);
            ph[p] = P_OP2;
          end else begin
            drive_req(p, 4'd0, $urandom);
          end
        end else begin
          drive_req(p, ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0, $urandom);
        end
      end
      tick();
    end
    pending = 0;
    for (int p = 0; p < 4; p++) if (ph[p] != P_FREE) pending++;
    check("rnd_drain", pending, 0);
    check("rnd_activity", (issued > 100) && (completed > 100), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
